hello_nios_sram_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the Nios on-chip SRAM's s2 port. It accepts a byte stream (UART/JTAG receiver), packs bytes little-endian into 32-bit words, and writes them into SRAM starting at word 0 while holding the CPU in reset. It keeps a running byte checksum and, when configured, reads the image back to verify it.

---
 rtl/hello_nios_sram_loader.sv | 214 +++++++++++++++++++++
 tb/tb_hello_nios_sram_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hello_nios_sram_loader.sv
// Byte-stream boot loader: packs bytes little-endian into SRAM words while holding the Nios in reset.
// Optional readback verify compiled in with HELLO_NIOS_SRAM_LOADER_VERIFY_EN.
module hello_nios_sram_loader #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       length,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [3:0]        sram_byteenable,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [31:0]       sram_writedata,
    input  logic [31:0]       sram_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    output logic              cpu_reset_req
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLUSH, S_VERIFY, S_CHECK, S_DONE
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(4 * DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       idx_q;
    logic [31:0]       pack_q;
    logic [3:0]        pack_be_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              wr_pend_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [31:0]       checksum_q;
    logic              error_q;

    logic        len_ok;
    logic        accept;
    logic        last_byte;
    logic [31:0] byte_word;
    logic [3:0]  lane_be;

    assign len_ok    = (length != 16'd0) && ({1'b0, length} <= MAX_LEN);
    assign accept    = s_valid && (state_q == S_LOAD);
    assign last_byte = accept && (idx_q == len_q - 16'd1);
    assign byte_word = {24'b0, s_data} << {idx_q[1:0], 3'b000};
    assign lane_be   = 4'b0001 << idx_q[1:0];

`ifdef HELLO_NIOS_SRAM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_vld_q;
    logic              rd_last_q;
    logic [31:0]       vsum_q, vsum_d;
    logic [ADDR_W-1:0] last_word;
    logic [3:0]        tail_be;
    logic [3:0]        rd_mask;
    logic [7:0]        rd_lane [4];

    assign last_word = ADDR_W'((len_q - 16'd1) >> 2);

    always_comb begin
        tail_be = 4'hF;
        case (len_q[1:0])
            2'd1:    tail_be = 4'b0001;
            2'd2:    tail_be = 4'b0011;
            2'd3:    tail_be = 4'b0111;
            default: tail_be = 4'hF;
        endcase
    end

    // Only the final word of the image can carry lanes past the end.
    assign rd_mask = rd_last_q ? tail_be : 4'hF;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = rd_mask[gi] ? sram_readdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign vsum_d = vsum_q + 32'(rd_lane[0]) + 32'(rd_lane[1])
                           + 32'(rd_lane[2]) + 32'(rd_lane[3]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            vsum_q    <= '0;
        end else begin
            rd_vld_q  <= (state_q == S_VERIFY);
            rd_last_q <= (state_q == S_VERIFY) && (rd_addr_q == last_word);
            if (state_q == S_VERIFY) rd_addr_q <= rd_addr_q + 1'b1;
            if (rd_vld_q) vsum_q <= vsum_d;
            if (state_q == S_IDLE && start && len_ok) begin
                rd_addr_q <= '0;
                vsum_q    <= '0;
            end
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^sram_readdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = len_ok ? S_LOAD : S_DONE;
            S_LOAD:  if (last_byte) state_d = S_FLUSH;
`ifdef HELLO_NIOS_SRAM_LOADER_VERIFY_EN
            S_FLUSH:  state_d = S_VERIFY;
            S_VERIFY: if (rd_addr_q == last_word) state_d = S_CHECK;
            S_CHECK:  state_d = S_DONE;
`else
            S_FLUSH:  state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready         = (state_q == S_LOAD);
        busy            = (state_q == S_LOAD) || (state_q == S_FLUSH) ||
                          (state_q == S_VERIFY) || (state_q == S_CHECK);
        cpu_reset_req   = busy;
        done            = (state_q == S_DONE);
        error           = error_q;
        checksum        = checksum_q;
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
        sram_address    = '0;
        sram_byteenable = 4'h0;
        sram_writedata  = 32'h0;
        if (wr_pend_q) begin
            sram_chipselect = 1'b1;
            sram_write      = 1'b1;
            sram_address    = word_addr_q;
            sram_byteenable = be_q;
            sram_writedata  = wdata_q;
        end
`ifdef HELLO_NIOS_SRAM_LOADER_VERIFY_EN
        if (state_q == S_VERIFY) begin
            sram_chipselect = 1'b1;
            sram_address    = rd_addr_q;
            sram_byteenable = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q       <= '0;
            idx_q       <= '0;
            pack_q      <= '0;
            pack_be_q   <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            wr_pend_q   <= 1'b0;
            word_addr_q <= '0;
            checksum_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            wr_pend_q <= 1'b0;
            if (wr_pend_q) word_addr_q <= word_addr_q + 1'b1;
            if (accept) begin
                checksum_q <= checksum_q + {24'b0, s_data};
                idx_q      <= idx_q + 16'd1;
                // A full or final word is handed to the write stage; the packer restarts empty.
                if (idx_q[1:0] == 2'd3 || last_byte) begin
                    wdata_q   <= pack_q | byte_word;
                    be_q      <= pack_be_q | lane_be;
                    wr_pend_q <= 1'b1;
                    pack_q    <= '0;
                    pack_be_q <= '0;
                end else begin
                    pack_q    <= pack_q | byte_word;
                    pack_be_q <= pack_be_q | lane_be;
                end
            end
`ifdef HELLO_NIOS_SRAM_LOADER_VERIFY_EN
            if (state_q == S_CHECK) error_q <= (vsum_d != checksum_q);
`endif
            if (state_q == S_IDLE && start) begin
                if (len_ok) begin
                    len_q       <= length;
                    idx_q       <= '0;
                    word_addr_q <= '0;
                    checksum_q  <= '0;
                    pack_q      <= '0;
                    pack_be_q   <= '0;
                    error_q     <= 1'b0;
                end else begin
                    error_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hello_nios_sram_loader.sv
// Self-checking bench for hello_nios_sram_loader: table vectors, randomized loads against a
// byte-list reference model, and hand sequences for reset, start-while-busy and verify mismatch.
module tb_hello_nios_sram_loader;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 10240;
`ifdef HELLO_NIOS_SRAM_LOADER_VERIFY_EN
    localparam int VX = 1;
`else
    localparam int VX = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       length = 16'd0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic [ADDR_W-1:0] sram_address;
    logic [3:0]        sram_byteenable;
    logic              sram_chipselect;
    logic              sram_write;
    logic [31:0]       sram_writedata;
    logic [31:0]       sram_readdata = 32'h0;
    logic              busy, done, error, cpu_reset_req;
    logic [31:0]       checksum;

    hello_nios_sram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sram_address(sram_address), .sram_byteenable(sram_byteenable),
        .sram_chipselect(sram_chipselect), .sram_write(sram_write),
        .sram_writedata(sram_writedata), .sram_readdata(sram_readdata),
        .busy(busy), .done(done), .error(error), .checksum(checksum),
        .cpu_reset_req(cpu_reset_req)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model with one-cycle read latency and optional bit-0 corruption on one address.
    typedef struct { int addr; logic [31:0] data; logic [3:0] be; } wr_t;
    wr_t         wlog[$];
    int          cs_cnt = 0;
    int          corrupt_addr = -1;
    logic [31:0] mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (sram_chipselect) begin
            cs_cnt <= cs_cnt + 1;
            if (sram_write) begin
                wlog.push_back('{int'(sram_address), sram_writedata, sram_byteenable});
                for (int b = 0; b < 4; b++)
                    if (sram_byteenable[b]) mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
            end else begin
                sram_readdata <= mem[sram_address] ^ {31'b0, (int'(sram_address) == corrupt_addr)};
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] tx_bytes [0:40959];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drives one load and checks it against the reference model built from tx_bytes.
    task automatic run_load(input string tag, input int len, input int stall, input bit mid_start,
                            input bit exp_err, input int exp_lat);
        bit          legal, got_done, v;
        int          nw, wbase, csbase, idx, lat, st, nbad, firstbad;
        logic [31:0] sum_m, mdata;
        logic [3:0]  mbe;
        legal = (len >= 1) && (len <= 4 * DEPTH);
        nw    = legal ? (len + 3) / 4 : 0;
        sum_m = 0;
        if (legal) for (int i = 0; i < len; i++) sum_m += 32'(tx_bytes[i]);
        wbase  = wlog.size();
        csbase = cs_cnt;
        @(negedge clk);
        start = 1'b1; length = 16'(len); st = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy"}, 64'(busy), 64'(legal));
        chk({tag, " cpu_reset_req"}, 64'(cpu_reset_req), 64'(legal));
        idx = 0; got_done = 0; lat = -1;
        for (int n = 0; n < 4 * len + 200 && !got_done; n++) begin
            if (done) begin
                got_done = 1;
                lat = cyc - st;
            end else begin
                v = (idx < len) && (stall == 0 || (stall == 1 && n % 2 == 0) ||
                                    (stall == 2 && $urandom_range(1) == 1));
                s_valid = v;
                s_data  = v ? tx_bytes[idx] : 8'h00;
                if (v && s_ready) idx++;
                start = mid_start && (n == 3);
                if (mid_start && n == 3) length = 16'd4;
                @(negedge clk);
            end
        end
        s_valid = 1'b0; start = 1'b0;
        chk({tag, " done seen"}, 64'(got_done), 64'd1);
        if (got_done && exp_lat >= 0) chk({tag, " done latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        if (legal) chk({tag, " checksum"}, 64'(checksum), 64'(sum_m));
        chk({tag, " write count"}, 64'(wlog.size() - wbase), 64'(nw));
        chk({tag, " chipselect cycles"}, 64'(cs_cnt - csbase), 64'(nw * (1 + VX)));
        nbad = 0; firstbad = -1;
        for (int w = 0; w < nw && wbase + w < wlog.size(); w++) begin
            mdata = 0; mbe = 0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < len) begin
                    mdata[8*b +: 8] = tx_bytes[4*w + b];
                    mbe[b] = 1'b1;
                end
            if (wlog[wbase+w].addr != w || wlog[wbase+w].data !== mdata || wlog[wbase+w].be !== mbe) begin
                nbad++;
                if (firstbad < 0) firstbad = w;
            end
        end
        if (nbad != 0)
            $display("  %s first bad word %0d: addr=%0d data=%h be=%b", tag, firstbad,
                     wlog[wbase+firstbad].addr, wlog[wbase+firstbad].data, wlog[wbase+firstbad].be);
        chk({tag, " bad words"}, 64'(nbad), 64'd0);
        $display("load %s len=%0d stall=%0d lat=%0d err=%0b sum=%h", tag, len, stall, lat, error, checksum);
    endtask

    typedef struct {
        string tag; int len; int base; int step; int stall;
        logic [31:0] sum; bit err; int lat;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   idx, len, stall, wbase;
        bit   mid;
        tbl[0] = '{"inc8",     8,     8'h01, 1,     0, 32'h24,     1'b0, 10 + 3 * VX};
        tbl[1] = '{"part5",    5,     8'hAA, 8'h11, 0, 32'h3FC,    1'b0, 7 + 3 * VX};
        tbl[2] = '{"len0",     0,     0,     0,     0, 32'h0,      1'b1, 1};
        tbl[3] = '{"len40961", 40961, 0,     0,     0, 32'h0,      1'b1, 1};
        tbl[4] = '{"stall12",  12,    8'h01, 1,     1, 32'h4E,     1'b0, -1};
        tbl[5] = '{"max",      40960, 0,     1,     0, 32'h4FB000, 1'b0, 40962 + 10241 * VX};

        repeat (3) @(negedge clk);
        chk("reset outputs", 64'({s_ready, sram_address, sram_byteenable, sram_chipselect, sram_write,
                                   sram_writedata, busy, done, error, checksum, cpu_reset_req}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[k]) begin
            for (int i = 0; i < 40960; i++) tx_bytes[i] = 8'(tbl[k].base + tbl[k].step * i);
            run_load(tbl[k].tag, tbl[k].len, tbl[k].stall, 1'b0, tbl[k].err, tbl[k].lat);
            if (!tbl[k].err) chk({tbl[k].tag, " table checksum"}, 64'(checksum), 64'(tbl[k].sum));
        end

        for (int r = 0; r < 20; r++) begin
            len   = $urandom_range(1, 40);
            stall = $urandom_range(2);
            mid   = (len >= 4) && ($urandom_range(1) == 1);
            for (int i = 0; i < len; i++) tx_bytes[i] = 8'($urandom);
            run_load($sformatf("rand%0d", r), len, stall, mid, 1'b0,
                     stall == 0 ? len + 2 + VX * ((len + 3) / 4 + 1) : -1);
        end

        // Reset after 6 of 16 bytes: outputs drop at once and no further writes appear.
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
        wbase = wlog.size();
        @(negedge clk);
        start = 1'b1; length = 16'd16;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        for (int n = 0; n < 50 && idx < 6; n++) begin
            s_valid = 1'b1; s_data = tx_bytes[idx];
            if (s_ready) idx++;
            @(negedge clk);
        end
        chk("rst accepted bytes", 64'(idx), 64'd6);
        reset = 1'b1;
        #1;
        chk("rst outputs", 64'({s_ready, sram_address, sram_byteenable, sram_chipselect, sram_write,
                                 sram_writedata, busy, done, error, checksum, cpu_reset_req}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst s_ready after", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        chk("rst writes before abort only", 64'(wlog.size() - wbase), 64'd1);
        $display("load reset_mid len=16 accepted=%0d", idx);
        for (int i = 0; i < 4; i++) tx_bytes[i] = 8'(8'h10 + i);
        run_load("after_rst", 4, 0, 1'b0, 1'b0, 6 + 2 * VX);

        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
        run_load("mid_start", 16, 0, 1'b1, 1'b0, 18 + 5 * VX);

`ifdef HELLO_NIOS_SRAM_LOADER_VERIFY_EN
        for (int i = 0; i < 8; i++) tx_bytes[i] = 8'(i + 1);
        corrupt_addr = 1;
        run_load("verify_mismatch", 8, 0, 1'b0, 1'b1, 13);
        chk("verify_mismatch checksum", 64'(checksum), 64'h24);
        corrupt_addr = -1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
